// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the debug/console UART pair.
//   CLKS_PER_BIT_DEFAULT : clocks per bit for 25 MHz / 115200 baud (also used by the transmitter)
//   DATA_W               : data bits per frame
//   CNT_W                : width of the bit-period counter
//   rx_state_t           : receiver FSM state encoding
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 217;
  localparam int DATA_W               = 8;
  localparam int CNT_W                = 10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_STOP       = 3'd3,
    ST_CLEANUP    = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
// Both flops reset to 1 so an idle-high line reads idle during and after reset.
//   i_Clock   : destination clock
//   i_Reset_n : asynchronous active-low reset
//   d         : asynchronous input bit
//   q         : synchronized output bit
module sync_2ff (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
//   i_Clock     : system clock
//   i_Reset_n   : asynchronous active-low reset
//   i_RX_Serial : asynchronous serial line, idles high
//   o_RX_DV     : one-cycle strobe, o_RX_Byte holds a good byte
//   o_RX_Byte   : last good byte, held until the next good byte
//   o_RX_Active : high from start-bit detection until return to IDLE
//   o_Frame_Err : one-cycle strobe, stop bit sampled low
//   o_Break     : one-cycle strobe, all-zero frame with stop bit low
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for s=0 while armed
// START      | counting to the start-bit midpoint, rejecting glitches
// DATA       | sampling 8 data bits, one per bit period
// STOP       | sampling the stop bit, issuing DV / frame error / break
// CLEANUP    | one cycle before returning to IDLE
// BREAK_WAIT | line held low after a break; wait for it to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_RX_Serial,
  output logic              o_RX_DV,
  output logic [DATA_W-1:0] o_RX_Byte,
  output logic              o_RX_Active,
  output logic              o_Frame_Err,
  output logic              o_Break
);

  // START lands on its midpoint H cycles after T0; the counter starts at 0 in
  // the cycle after T0, hence the -1.
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  logic              s;
  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              armed;
  // The synchronizer flops reset to 1, so s reads high for two cycles after
  // reset regardless of the pin. Arming waits until those reset values have
  // been flushed so a line held low through reset release is never taken as
  // idle.
  logic [1:0]        flush;

  sync_2ff u_sync (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .d         (i_RX_Serial),
    .q         (s)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      armed       <= 1'b0;
      flush       <= 2'b00;
      o_RX_DV     <= 1'b0;
      o_RX_Byte   <= '0;
      o_RX_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Break     <= 1'b0;
    end else begin
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Break     <= 1'b0;
      flush       <= {flush[0], 1'b1};
      if (flush[1] && s) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (armed && !s) begin
            state       <= ST_START;
            o_RX_Active <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt == HALF_TC) begin
            cnt <= '0;
            if (!s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state       <= ST_IDLE;
              o_RX_Active <= 1'b0;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        ST_DATA: begin
          if (cnt == BIT_TC) begin
            cnt            <= '0;
            shreg[bit_idx] <= s;
            if (bit_idx == 3'd7) state <= ST_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        ST_STOP: begin
          if (cnt == BIT_TC) begin
            cnt <= '0;
            if (s) begin
              o_RX_DV   <= 1'b1;
              o_RX_Byte <= shreg;
              state     <= ST_CLEANUP;
            end else if (shreg == '0) begin
              o_Frame_Err <= 1'b1;
              o_Break     <= 1'b1;
              state       <= ST_BREAK_WAIT;
            end else begin
              o_Frame_Err <= 1'b1;
              state       <= ST_CLEANUP;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        ST_CLEANUP: begin
          state       <= ST_IDLE;
          o_RX_Active <= 1'b0;
        end

        ST_BREAK_WAIT: begin
          if (s) begin
            state       <= ST_IDLE;
            o_RX_Active <= 1'b0;
          end
        end

        default: begin
          state       <= ST_IDLE;
          o_RX_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with CLKS_PER_BIT=16.
// The line is driven bit-accurately; expected bytes and their DV cycle are
// queued when a frame is driven and matched against what a monitor captures.
module tb_uart_rx;

  localparam int C   = 16;
  localparam int H   = (C - 1) / 2;
  // pin edge driven in cycle n -> s low in n+2 (T0) -> stop sample at T0+H+9C -> DV one cycle later
  localparam int LAT = 3 + H + 9 * C;

  logic       i_Clock = 1'b0;
  logic       i_Reset_n;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_Frame_Err;
  logic       o_Break;

  always #5 i_Clock = ~i_Clock;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock     (i_Clock),
    .i_Reset_n   (i_Reset_n),
    .i_RX_Serial (i_RX_Serial),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte),
    .o_RX_Active (o_RX_Active),
    .o_Frame_Err (o_Frame_Err),
    .o_Break     (o_Break)
  );

  typedef struct {
    logic [7:0] b;
    int         t;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  got_q[$];
  int   cyc = 0;
  int   dv_cnt = 0, fe_cnt = 0, brk_cnt = 0, act_cnt = 0, ovl_cnt = 0;
  int   fe_cyc = -1, brk_cyc = -1;
  logic act_at[int];
  int   n_checks = 0, n_pass = 0;

  always @(posedge i_Clock) cyc <= cyc + 1;

  always @(negedge i_Clock) begin
    if (i_Reset_n) begin
      act_at[cyc] = o_RX_Active;
      if (o_RX_Active) act_cnt++;
      if (o_RX_DV) begin
        got_q.push_back('{o_RX_Byte, cyc});
        dv_cnt++;
      end
      if (o_Frame_Err) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (o_Break) begin
        brk_cnt++;
        brk_cyc = cyc;
      end
      if (o_RX_DV && o_Frame_Err) ovl_cnt++;
    end
  end

  task automatic drive_bit(input logic b);
    i_RX_Serial = b;
    repeat (C) @(posedge i_Clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit push);
    if (push) exp_q.push_back('{d, cyc + LAT});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int cycles);
    i_RX_Serial = 1'b1;
    repeat (cycles) @(posedge i_Clock);
    #1;
  endtask

  task automatic test_reset;
    i_Reset_n   = 1'b0;
    i_RX_Serial = 1'b1;
    repeat (4) @(posedge i_Clock);
    #1;
    n_checks++;
    if ({o_RX_DV, o_RX_Byte, o_RX_Active, o_Frame_Err, o_Break} !== 12'h000)
      $display("FAIL reset_outputs: got dv=%b byte=%02h act=%b fe=%b brk=%b, expected all 0",
               o_RX_DV, o_RX_Byte, o_RX_Active, o_Frame_Err, o_Break);
    else n_pass++;
    i_Reset_n = 1'b1;
    idle(2 * C);
    n_checks++;
    if (act_cnt !== 0) $display("FAIL reset_idle_active: got %0d active cycles, expected 0", act_cnt);
    else n_pass++;
    n_checks++;
    if (dv_cnt !== 0) $display("FAIL reset_idle_dv: got %0d DV pulses, expected 0", dv_cnt);
    else n_pass++;
  endtask

  task automatic test_clean_frame;
    ev_t e, g;
    int  fe0, brk0;
    fe0 = fe_cnt; brk0 = brk_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(2 * C);
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() == 0) $display("FAIL clean_dv_present: got no DV, expected byte %02h", e.b);
    else begin
      n_pass++;
      g = got_q.pop_front();
      n_checks++;
      if (g.b !== e.b) $display("FAIL clean_byte: got %02h, expected %02h", g.b, e.b);
      else n_pass++;
      n_checks++;
      if (g.t !== e.t) $display("FAIL clean_dv_cycle: got %0d, expected %0d", g.t, e.t);
      else n_pass++;
      n_checks++;
      if (act_at[g.t] !== 1'b1) $display("FAIL clean_active_at_dv: got %b, expected 1", act_at[g.t]);
      else n_pass++;
      n_checks++;
      if (act_at[g.t + 2] !== 1'b0) $display("FAIL clean_active_fall: got %b, expected 0", act_at[g.t + 2]);
      else n_pass++;
    end
    n_checks++;
    if (o_RX_Byte !== 8'hA5) $display("FAIL clean_byte_held: got %02h, expected a5", o_RX_Byte);
    else n_pass++;
    n_checks++;
    if ((fe_cnt - fe0) !== 0 || (brk_cnt - brk0) !== 0)
      $display("FAIL clean_no_err: got fe=%0d brk=%0d, expected 0 0", fe_cnt - fe0, brk_cnt - brk0);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    ev_t e, g;
    int  fe0;
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(2 * C);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL b2b_dv_present%0d: got no DV, expected byte %02h", i, e.b);
      else begin
        n_pass++;
        g = got_q.pop_front();
        n_checks++;
        if (g.b !== e.b) $display("FAIL b2b_byte%0d: got %02h, expected %02h", i, g.b, e.b);
        else n_pass++;
        n_checks++;
        if (g.t !== e.t) $display("FAIL b2b_dv_cycle%0d: got %0d, expected %0d", i, g.t, e.t);
        else n_pass++;
      end
    end
    n_checks++;
    if ((fe_cnt - fe0) !== 0) $display("FAIL b2b_no_err: got %0d frame errors, expected 0", fe_cnt - fe0);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int n, dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    i_RX_Serial = 1'b0;
    n = cyc;
    repeat (3) @(posedge i_Clock);
    #1;
    idle(3 * C);
    n_checks++;
    if (act_at[n + 3] !== 1'b1) $display("FAIL glitch_active_rise: got %b, expected 1", act_at[n + 3]);
    else n_pass++;
    n_checks++;
    if (act_at[n + 3 + H] !== 1'b0) $display("FAIL glitch_active_fall: got %b, expected 0", act_at[n + 3 + H]);
    else n_pass++;
    n_checks++;
    if ((dv_cnt - dv0) !== 0 || (fe_cnt - fe0) !== 0)
      $display("FAIL glitch_no_strobe: got dv=%0d fe=%0d, expected 0 0", dv_cnt - dv0, fe_cnt - fe0);
    else n_pass++;
  endtask

  task automatic test_frame_err;
    int n, dv0, fe0, brk0;
    dv0 = dv_cnt; fe0 = fe_cnt; brk0 = brk_cnt;
    n = cyc;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2 * C);
    n_checks++;
    if ((fe_cnt - fe0) !== 1) $display("FAIL ferr_count: got %0d, expected 1", fe_cnt - fe0);
    else n_pass++;
    n_checks++;
    if (fe_cyc !== n + LAT) $display("FAIL ferr_cycle: got %0d, expected %0d", fe_cyc, n + LAT);
    else n_pass++;
    n_checks++;
    if ((dv_cnt - dv0) !== 0 || (brk_cnt - brk0) !== 0)
      $display("FAIL ferr_no_dv_brk: got dv=%0d brk=%0d, expected 0 0", dv_cnt - dv0, brk_cnt - brk0);
    else n_pass++;
    n_checks++;
    if (o_RX_Byte !== 8'hFF) $display("FAIL ferr_byte_held: got %02h, expected ff", o_RX_Byte);
    else n_pass++;
  endtask

  task automatic test_break;
    ev_t e, g;
    int  n, m, dv0, fe0, brk0, lows;
    dv0 = dv_cnt; fe0 = fe_cnt; brk0 = brk_cnt;
    i_RX_Serial = 1'b0;
    n = cyc;
    repeat (20 * C) @(posedge i_Clock);
    #1;
    m = cyc;
    idle(2 * C);
    n_checks++;
    if ((fe_cnt - fe0) !== 1 || (brk_cnt - brk0) !== 1)
      $display("FAIL break_count: got fe=%0d brk=%0d, expected 1 1", fe_cnt - fe0, brk_cnt - brk0);
    else n_pass++;
    n_checks++;
    if (brk_cyc !== n + LAT || fe_cyc !== n + LAT)
      $display("FAIL break_cycle: got brk=%0d fe=%0d, expected %0d", brk_cyc, fe_cyc, n + LAT);
    else n_pass++;
    n_checks++;
    if ((dv_cnt - dv0) !== 0) $display("FAIL break_no_dv: got %0d, expected 0", dv_cnt - dv0);
    else n_pass++;
    lows = 0;
    for (int t = n + 3; t <= m + 2; t++) if (act_at[t] !== 1'b1) lows++;
    n_checks++;
    if (lows !== 0) $display("FAIL break_active_held: got %0d inactive cycles, expected 0", lows);
    else n_pass++;
    n_checks++;
    if (act_at[m + 3] !== 1'b0) $display("FAIL break_active_fall: got %b, expected 0", act_at[m + 3]);
    else n_pass++;
    send_frame(8'h11, 1'b1, 1'b1);
    idle(2 * C);
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() == 0) $display("FAIL break_next_present: got no DV, expected byte %02h", e.b);
    else begin
      n_pass++;
      g = got_q.pop_front();
      n_checks++;
      if (g.b !== e.b || g.t !== e.t)
        $display("FAIL break_next_byte: got %02h@%0d, expected %02h@%0d", g.b, g.t, e.b, e.t);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort;
    ev_t        e, g;
    logic [7:0] d;
    int         dv0, fe0, a0;
    d = 8'h5A;
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    i_RX_Serial = d[4];
    repeat (C / 2) @(posedge i_Clock);
    #1;
    i_Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({o_RX_DV, o_RX_Byte, o_RX_Active, o_Frame_Err, o_Break} !== 12'h000)
      $display("FAIL abort_outputs: got dv=%b byte=%02h act=%b fe=%b brk=%b, expected all 0",
               o_RX_DV, o_RX_Byte, o_RX_Active, o_Frame_Err, o_Break);
    else n_pass++;
    i_RX_Serial = 1'b0;
    repeat (3) @(posedge i_Clock);
    #1;
    a0 = act_cnt;
    i_Reset_n = 1'b1;
    repeat (4 * C) @(posedge i_Clock);
    #1;
    n_checks++;
    if ((act_cnt - a0) !== 0) $display("FAIL abort_low_line_active: got %0d active cycles, expected 0", act_cnt - a0);
    else n_pass++;
    n_checks++;
    if ((dv_cnt - dv0) !== 0 || (fe_cnt - fe0) !== 0)
      $display("FAIL abort_no_strobe: got dv=%0d fe=%0d, expected 0 0", dv_cnt - dv0, fe_cnt - fe0);
    else n_pass++;
    idle(2 * C);
    send_frame(d, 1'b1, 1'b1);
    idle(2 * C);
    e = exp_q.pop_front();
    n_checks++;
    if (got_q.size() == 0) $display("FAIL abort_rx_present: got no DV, expected byte %02h", e.b);
    else begin
      n_pass++;
      g = got_q.pop_front();
      n_checks++;
      if (g.b !== e.b || g.t !== e.t)
        $display("FAIL abort_rx_byte: got %02h@%0d, expected %02h@%0d", g.b, g.t, e.b, e.t);
      else n_pass++;
    end
    n_checks++;
    if (got_q.size() !== 0) $display("FAIL extra_dv: got %0d unexpected DV pulses, expected 0", got_q.size());
    else n_pass++;
    n_checks++;
    if (ovl_cnt !== 0) $display("FAIL dv_fe_overlap: got %0d overlapping cycles, expected 0", ovl_cnt);
    else n_pass++;
  endtask

  initial begin
    i_Reset_n   = 1'b0;
    i_RX_Serial = 1'b1;
    @(posedge i_Clock);
    #1;
    test_reset;
    test_clean_frame;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_break;
    test_reset_abort;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
